// File: rtl/alu_seq.sv
// Registered ALU with a start/busy/done handshake: single-cycle ops answer at latency 1, MUL at
// latency WIDTH, SHLN/SHRN at latency amt. A start seen while busy is dropped, never queued.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       ALUOp,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             c_i,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rslt,
  output logic [WIDTH-1:0] rslt_hi,
  output logic             c_o,
  output logic             zero,
  output logic             equal,
  output logic             gt,
  output logic             lt
);

  localparam logic [4:0] OP_ADD  = 5'b00111;
  localparam logic [4:0] OP_SUB  = 5'b01110;
  localparam logic [4:0] OP_DEC  = 5'b00010;
  localparam logic [4:0] OP_XOR  = 5'b10000;
  localparam logic [4:0] OP_AND  = 5'b01111;
  localparam logic [4:0] OP_OR   = 5'b10101;
  localparam logic [4:0] OP_LSR  = 5'b10001;
  localparam logic [4:0] OP_LSL  = 5'b10011;
  localparam logic [4:0] OP_RRC  = 5'b10010;
  localparam logic [4:0] OP_RLC  = 5'b10100;
  localparam logic [4:0] OP_ASR  = 5'b11000;
  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_MUL  = 5'b11001;
  localparam logic [4:0] OP_SHLN = 5'b11010;
  localparam logic [4:0] OP_SHRN = 5'b11011;

  typedef enum logic {S_IDLE, S_RUN} state_t;
  typedef enum logic [1:0] {M_MUL, M_SHL, M_SHR} mode_t;

  state_t             state_q;
  mode_t              mode_q;
  logic [SHW-1:0]     cnt_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   sh_q;
  logic               shc_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   rslt_q;
  logic [WIDTH-1:0]   rslt_hi_q;
  logic               c_o_q;
  logic               zero_q;
  logic               equal_q;
  logic               gt_q;
  logic               lt_q;

  logic [SHW-1:0]     amt;
  logic [WIDTH-1:0]   op_rslt;
  logic               op_co;
  logic               op_eq;
  logic               op_gt;
  logic               op_lt;
  logic               op_cmp;
  logic               op_known;
  logic               op_zero;
  logic               op_multi;

  assign amt = inB[SHW-1:0];

  // For SHLN/SHRN this also produces the first shift step when the op goes multi-cycle.
  always_comb begin
    op_rslt  = '0;
    op_co    = 1'b0;
    op_eq    = 1'b0;
    op_gt    = 1'b0;
    op_lt    = 1'b0;
    op_cmp   = 1'b0;
    op_known = 1'b1;
    case (ALUOp)
      OP_ADD: {op_co, op_rslt} = {1'b0, inA} + {1'b0, inB} + {{WIDTH{1'b0}}, c_i};
      OP_SUB: {op_co, op_rslt} = {1'b0, inA} - {1'b0, inB} + {{WIDTH{1'b0}}, c_i};
      OP_DEC: op_rslt = inA - WIDTH'(1);
      OP_XOR: op_rslt = inA ^ inB;
      OP_AND: op_rslt = inA & inB;
      OP_OR:  op_rslt = inA | inB;
      OP_LSR: begin
        op_rslt = {1'b0, inA[WIDTH-1:1]};
        op_co   = inA[0];
      end
      OP_LSL: begin
        op_rslt = {inA[WIDTH-2:0], 1'b0};
        op_co   = inA[WIDTH-1];
      end
      OP_RRC: begin
        op_rslt = {c_i, inA[WIDTH-1:1]};
        op_co   = inA[0];
      end
      OP_RLC: begin
        op_rslt = {inA[WIDTH-2:0], c_i};
        op_co   = inA[WIDTH-1];
      end
      OP_ASR: op_rslt = {inA[WIDTH-1], inA[WIDTH-1:1]};
      OP_CMP: begin
        op_cmp = 1'b1;
        op_eq  = (inA == inB);
        op_gt  = ($signed(inA) > $signed(inB));
        op_lt  = ($signed(inA) < $signed(inB));
      end
      OP_MUL: op_rslt = '0;
      OP_SHLN: begin
        if (amt != '0) begin
          op_rslt = {inA[WIDTH-2:0], 1'b0};
          op_co   = inA[WIDTH-1];
        end else begin
          op_rslt = inA;
        end
      end
      OP_SHRN: begin
        if (amt != '0) begin
          op_rslt = {1'b0, inA[WIDTH-1:1]};
          op_co   = inA[0];
        end else begin
          op_rslt = inA;
        end
      end
      default: op_known = 1'b0;
    endcase
    op_zero  = op_cmp ? op_eq : (op_known && (op_rslt == '0));
    op_multi = (ALUOp == OP_MUL) ||
               (((ALUOp == OP_SHLN) || (ALUOp == OP_SHRN)) && (amt > SHW'(1)));
  end

  logic [2*WIDTH-1:0] prod_nx;
  logic [WIDTH-1:0]   sh_nx;
  logic               sh_out;

  assign prod_nx = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign sh_nx   = (mode_q == M_SHL) ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
  assign sh_out  = (mode_q == M_SHL) ? sh_q[WIDTH-1] : sh_q[0];

  // The accepting edge already performs the first iteration, so the counter starts one short.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mode_q    <= M_MUL;
      cnt_q     <= '0;
      prod_q    <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      sh_q      <= '0;
      shc_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rslt_q    <= '0;
      rslt_hi_q <= '0;
      c_o_q     <= 1'b0;
      zero_q    <= 1'b0;
      equal_q   <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (op_multi) begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
              if (ALUOp == OP_MUL) begin
                mode_q   <= M_MUL;
                prod_q   <= inB[0] ? {{WIDTH{1'b0}}, inA} : '0;
                mcand_q  <= {{(WIDTH-1){1'b0}}, inA, 1'b0};
                mplier_q <= {1'b0, inB[WIDTH-1:1]};
                cnt_q    <= SHW'(WIDTH-1);
              end else begin
                mode_q <= (ALUOp == OP_SHLN) ? M_SHL : M_SHR;
                sh_q   <= op_rslt;
                shc_q  <= op_co;
                cnt_q  <= amt - SHW'(1);
              end
            end else begin
              done_q    <= 1'b1;
              rslt_q    <= op_rslt;
              rslt_hi_q <= '0;
              c_o_q     <= op_co;
              zero_q    <= op_zero;
              equal_q   <= op_eq;
              gt_q      <= op_gt;
              lt_q      <= op_lt;
            end
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q - SHW'(1);
          if (mode_q == M_MUL) begin
            prod_q   <= prod_nx;
            mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
          end else begin
            sh_q  <= sh_nx;
            shc_q <= sh_out;
          end
          if (cnt_q == SHW'(1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            equal_q <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            if (mode_q == M_MUL) begin
              rslt_q    <= prod_nx[WIDTH-1:0];
              rslt_hi_q <= prod_nx[2*WIDTH-1:WIDTH];
              c_o_q     <= |prod_nx[2*WIDTH-1:WIDTH];
              zero_q    <= (prod_nx == '0);
            end else begin
              rslt_q    <= sh_nx;
              rslt_hi_q <= '0;
              c_o_q     <= sh_out;
              zero_q    <= (sh_nx == '0);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rslt    = rslt_q;
  assign rslt_hi = rslt_hi_q;
  assign c_o     = c_o_q;
  assign zero    = zero_q;
  assign equal   = equal_q;
  assign gt      = gt_q;
  assign lt      = lt_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: an 8-bit instance for datapath vectors, a 16-bit one for handshake.
module tb_alu_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic       start8, ci8;
  logic [4:0] op8;
  logic [7:0] a8, b8;
  logic       busy8, done8, co8, zero8, eq8, gt8, lt8;
  logic [7:0] r8, rh8;

  logic        start16, ci16;
  logic [4:0]  op16;
  logic [15:0] a16, b16;
  logic        busy16, done16, co16, zero16, eq16, gt16, lt16;
  logic [15:0] r16, rh16;

  alu_seq #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start8), .ALUOp(op8), .inA(a8), .inB(b8), .c_i(ci8),
    .busy(busy8), .done(done8), .rslt(r8), .rslt_hi(rh8), .c_o(co8), .zero(zero8),
    .equal(eq8), .gt(gt8), .lt(lt8)
  );

  alu_seq #(.WIDTH(16)) u16 (
    .clk(clk), .reset(reset), .start(start16), .ALUOp(op16), .inA(a16), .inB(b16), .c_i(ci16),
    .busy(busy16), .done(done16), .rslt(r16), .rslt_hi(rh16), .c_o(co16), .zero(zero16),
    .equal(eq16), .gt(gt16), .lt(lt16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue8(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic c);
    @(negedge clk);
    op8 = op; a8 = a; b8 = b; ci8 = c; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic issue16(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic c);
    @(negedge clk);
    op16 = op; a16 = a; b16 = b; ci16 = c; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
  endtask

  task automatic wait8(output int lat);
    lat = 1;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic wait16(output int lat);
    lat = 1;
    while (!done16 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int bad;
    reset = 1'b1;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; ci8 = 1'b0;
    start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; ci16 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_rslt", 32'(r8), 32'd0);
    chk("rst_flags", {27'd0, co8, zero8, eq8, gt8, lt8}, 32'd0);

    issue8(5'b00111, 8'hFF, 8'h01, 1'b0);
    chk("add_done", 32'(done8), 32'd1);
    chk("add_rslt", 32'(r8), 32'h00);
    chk("add_co", 32'(co8), 32'd1);
    chk("add_zero", 32'(zero8), 32'd1);

    // Issued in the ADD done cycle: back-to-back single-cycle ops.
    issue8(5'b01110, 8'h05, 8'h07, 1'b0);
    chk("sub_done", 32'(done8), 32'd1);
    chk("sub_rslt", 32'(r8), 32'hFE);
    chk("sub_co", 32'(co8), 32'd1);
    chk("sub_zero", 32'(zero8), 32'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done8), 32'd0);

    issue8(5'b00010, 8'h00, 8'h00, 1'b0);
    chk("dec_rslt", 32'(r8), 32'hFF);
    issue8(5'b10001, 8'h81, 8'h00, 1'b0);
    chk("lsr_rslt", 32'(r8), 32'h40);
    chk("lsr_co", 32'(co8), 32'd1);
    issue8(5'b11000, 8'h81, 8'h00, 1'b0);
    chk("asr_rslt", 32'(r8), 32'hC0);
    issue8(5'b10100, 8'h81, 8'h00, 1'b1);
    chk("rlc_rslt", 32'(r8), 32'h03);
    issue8(5'b10000, 8'hF0, 8'hFF, 1'b0);
    chk("xor_rslt", 32'(r8), 32'h0F);

    issue8(5'b11001, 8'd200, 8'd200, 1'b0);
    chk("mul_busy_c1", {30'd0, busy8, done8}, 32'h2);
    bad = 0;
    for (int k = 2; k <= 7; k++) begin
      @(posedge clk); #1;
      if (!busy8 || done8 || r8 != 8'h0F) bad++;
    end
    chk("mul_run_window", 32'(bad), 32'd0);
    @(posedge clk); #1;
    chk("mul_done_c8", 32'(done8), 32'd1);
    chk("mul_busy_c8", 32'(busy8), 32'd0);
    chk("mul_rslt", 32'(r8), 32'h40);
    chk("mul_rslt_hi", 32'(rh8), 32'h9C);
    chk("mul_co", 32'(co8), 32'd1);
    chk("mul_zero", 32'(zero8), 32'd0);

    issue8(5'b11001, 8'd13, 8'd11, 1'b0);
    wait8(lat);
    chk("mul2_lat", 32'(lat), 32'd8);
    chk("mul2_rslt", 32'(r8), 32'h8F);
    chk("mul2_rslt_hi", 32'(rh8), 32'h00);
    chk("mul2_co", 32'(co8), 32'd0);

    issue8(5'b11001, 8'h00, 8'hFF, 1'b0);
    wait8(lat);
    chk("mul0_rslt", 32'(r8), 32'h00);
    chk("mul0_zero", 32'(zero8), 32'd1);

    issue8(5'b00101, 8'h80, 8'h7F, 1'b0);
    chk("cmp_neg_flags", {27'd0, co8, zero8, eq8, gt8, lt8}, 32'h01);
    chk("cmp_neg_rslt", 32'(r8), 32'h00);
    issue8(5'b00101, 8'h33, 8'h33, 1'b0);
    chk("cmp_eq_flags", {27'd0, co8, zero8, eq8, gt8, lt8}, 32'h0C);

    issue8(5'b11010, 8'h81, 8'h03, 1'b0);
    chk("shln3_busy_c1", 32'(busy8), 32'd1);
    wait8(lat);
    chk("shln3_lat", 32'(lat), 32'd3);
    chk("shln3_rslt", 32'(r8), 32'h08);
    chk("shln3_co", 32'(co8), 32'd0);

    issue8(5'b11011, 8'h81, 8'h01, 1'b0);
    chk("shrn1_done", 32'(done8), 32'd1);
    chk("shrn1_rslt", 32'(r8), 32'h40);
    chk("shrn1_co", 32'(co8), 32'd1);

    // inB=0x08 puts zero in the 3-bit amount field.
    issue8(5'b11010, 8'h5A, 8'h08, 1'b0);
    chk("shln0_done", 32'(done8), 32'd1);
    chk("shln0_rslt", 32'(r8), 32'h5A);
    chk("shln0_co", 32'(co8), 32'd0);

    issue8(5'b11001, 8'd200, 8'd200, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_busy", 32'(busy8), 32'd0);
    chk("rst_mid_done", 32'(done8), 32'd0);
    chk("rst_mid_rslt", 32'(r8), 32'd0);
    @(negedge clk) reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done8) bad++;
    end
    chk("rst_mid_no_done", 32'(bad), 32'd0);

    // Start held high through a 16-bit MUL, operands switched to an ADD while busy.
    @(negedge clk);
    op16 = 5'b11001; a16 = 16'd3; b16 = 16'd5; ci16 = 1'b0; start16 = 1'b1;
    @(posedge clk); #1;
    op16 = 5'b00111; a16 = 16'd1; b16 = 16'd1;
    wait16(lat);
    start16 = 1'b0;
    chk("held_lat", 32'(lat), 32'd16);
    chk("held_rslt", 32'(r16), 32'h000F);
    chk("held_rslt_hi", 32'(rh16), 32'h0000);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (done16 || r16 != 16'h000F) bad++;
    end
    chk("held_single_op", 32'(bad), 32'd0);

    issue16(5'b11001, 16'h0100, 16'h0100, 1'b0);
    wait16(lat);
    chk("mul16_lat", 32'(lat), 32'd16);
    chk("mul16_rslt", 32'(r16), 32'h0000);
    chk("mul16_rslt_hi", 32'(rh16), 32'h0001);
    chk("mul16_co_zero", {30'd0, co16, zero16}, 32'h2);
    op16 = 5'b11010; a16 = 16'h0001; b16 = 16'h0004; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    chk("donecyc_busy", 32'(busy16), 32'd1);
    wait16(lat);
    chk("donecyc_lat", 32'(lat), 32'd4);
    chk("donecyc_rslt", 32'(r16), 32'h0010);
    chk("donecyc_co", 32'(co16), 32'd0);

    issue16(5'b11001, 16'hFFFF, 16'hFFFF, 1'b0);
    wait16(lat);
    chk("mulmax_rslt", 32'(r16), 32'h0001);
    chk("mulmax_rslt_hi", 32'(rh16), 32'hFFFE);
    issue16(5'b11111, 16'hFFFF, 16'hFFFF, 1'b1);
    chk("unk_done", 32'(done16), 32'd1);
    chk("unk_rslt", {rh16, r16}, 32'd0);
    chk("unk_flags", {27'd0, co16, zero16, eq16, gt16, lt16}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
